// File: rtl/sensor_freq_calc.sv
// Period-to-frequency stage: averages 2^AVG_LOG2 period samples and divides
// (CLK_HZ << AVG_LOG2) by their sum with a bit-serial restoring divider.
module sensor_freq_calc #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned PW       = 24,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned NUMW     = 40,
  parameter int unsigned QW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          period_valid,
  input  logic [PW-1:0] period_in,
  output logic          period_ready,
  output logic          freq_valid,
  input  logic          freq_ready,
  output logic [QW-1:0] freq_out,
  output logic          div_err,
  output logic          busy
);

  localparam int unsigned SUMW = PW + AVG_LOG2;
  localparam int unsigned CW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned STW  = $clog2(NUMW + 1);

  localparam logic [1:0] ACC  = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [NUMW-1:0] NUM   = NUMW'(CLK_HZ) << AVG_LOG2;
  localparam logic [NUMW-1:0] QMAX  = {{(NUMW-QW){1'b0}}, {QW{1'b1}}};
  localparam logic [CW-1:0]   LAST  = CW'((1 << AVG_LOG2) - 1);
  localparam logic [STW-1:0]  STEPS = STW'(NUMW);

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [SUMW-1:0] sum;
  logic [SUMW-1:0] sum_nxt;
  logic [NUMW-1:0] quo;
  logic [NUMW-1:0] rem;
  logic [NUMW-1:0] dvs;
  logic [NUMW:0]   rem_sh;
  logic            rem_ge;
  logic [STW-1:0]  step;
  logic [QW-1:0]   fout;
  logic            ferr;

  always_comb begin
    sum_nxt = sum + SUMW'(period_in);
    rem_sh  = {rem, quo[NUMW-1]};
    rem_ge  = (rem_sh >= {1'b0, dvs});
  end

  assign period_ready = (state == ACC);
  assign busy         = (state != ACC);
  assign freq_valid   = (state == DONE);
  assign freq_out     = fout;
  assign div_err      = ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      cnt   <= '0;
      sum   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      step  <= '0;
      fout  <= '0;
      ferr  <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (period_valid) begin
            if (cnt == LAST) begin
              quo   <= NUM;
              rem   <= '0;
              dvs   <= NUMW'(sum_nxt);
              cnt   <= '0;
              sum   <= '0;
              step  <= '0;
              state <= DIV;
            end else begin
              sum <= sum_nxt;
              cnt <= cnt + 1'b1;
            end
          end
        end
        DIV: begin
          // NUMW shift/subtract steps, then one extra cycle to saturate and register
          if (step != STEPS) begin
            step <= step + 1'b1;
            if (dvs != '0) begin
              if (rem_ge) begin
                rem <= rem_sh[NUMW-1:0] - dvs;
                quo <= {quo[NUMW-2:0], 1'b1};
              end else begin
                rem <= rem_sh[NUMW-1:0];
                quo <= {quo[NUMW-2:0], 1'b0};
              end
            end
          end else begin
            state <= DONE;
            if (dvs == '0) begin
              fout <= '0;
              ferr <= 1'b1;
            end else if (quo > QMAX) begin
              fout <= '1;
              ferr <= 1'b0;
            end else begin
              fout <= quo[QW-1:0];
              ferr <= 1'b0;
            end
          end
        end
        DONE: begin
          if (freq_ready) state <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_freq_calc.sv
// Scoreboard bench for sensor_freq_calc: expected results are queued by the
// stimulus thread and popped by a negedge monitor on each output handshake.
module tb_sensor_freq_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic        period_valid;
  logic [23:0] period_in;
  logic        period_ready;
  logic        freq_valid;
  logic        freq_ready;
  logic [31:0] freq_out;
  logic        div_err;
  logic        busy;

  logic        s_valid;
  logic [23:0] s_in;
  logic        s_pready;
  logic        s_fv;
  logic [15:0] s_out;
  logic        s_err;
  logic        s_busy;

  sensor_freq_calc #(.CLK_HZ(50_000_000), .PW(24), .AVG_LOG2(2), .NUMW(40), .QW(32)) dut (
    .clk(clk), .rst(rst), .period_valid(period_valid), .period_in(period_in),
    .period_ready(period_ready), .freq_valid(freq_valid), .freq_ready(freq_ready),
    .freq_out(freq_out), .div_err(div_err), .busy(busy));

  sensor_freq_calc #(.CLK_HZ(50_000_000), .PW(24), .AVG_LOG2(2), .NUMW(40), .QW(16)) dut16 (
    .clk(clk), .rst(rst), .period_valid(s_valid), .period_in(s_in),
    .period_ready(s_pready), .freq_valid(s_fv), .freq_ready(1'b1),
    .freq_out(s_out), .div_err(s_err), .busy(s_busy));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned results = 0;
  int unsigned rise_cyc = 0;
  int unsigned vlen = 0;
  logic [32:0] expq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Monitor: stability while stalled, scoreboard compare on handshake
  logic        prev_fv = 1'b0;
  logic [31:0] hold_f;
  logic        hold_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_fv = 1'b0;
    end else begin
      if (freq_valid) begin
        if (!prev_fv) begin
          rise_cyc = cyc;
          vlen = 0;
          hold_f = freq_out;
          hold_e = div_err;
        end else begin
          check("hold_freq_out", 64'(freq_out), 64'(hold_f));
          check("hold_div_err", 64'(div_err), 64'(hold_e));
        end
        vlen++;
        if (freq_ready) begin
          if (expq.size() == 0) begin
            total++;
            $display("FAIL unexpected_result actual=%0d required=none", freq_out);
          end else begin
            logic [32:0] e;
            e = expq.pop_front();
            check("freq_out", 64'(freq_out), 64'(e[31:0]));
            check("div_err", 64'(div_err), 64'(e[32]));
          end
          results++;
        end
      end
      prev_fv = freq_valid;
    end
  end

  task automatic send(input logic [23:0] p);
    int n = 0;
    logic ok = 1'b0;
    period_valid = 1'b1;
    period_in = p;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = period_ready;
      @(posedge clk); #1;
      n++;
    end
    period_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL send_timeout actual=0 required=1");
    end
  endtask

  task automatic send4(input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] c, input logic [23:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic wait_results(input int unsigned n);
    int k = 0;
    while (results < n && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check("result_count", 64'(results), 64'(n));
  endtask

  task automatic push(input logic err, input logic [31:0] f);
    expq.push_back({err, f});
  endtask

  initial begin
    int unsigned c0;
    int k;
    rst = 1'b1; period_valid = 1'b0; period_in = '0; freq_ready = 1'b1;
    s_valid = 1'b0; s_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_freq_valid", 64'(freq_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_period_ready", 64'(period_ready), 64'd1);
    check("rst_freq_out", 64'(freq_out), 64'd0);
    check("rst_div_err", 64'(div_err), 64'd0);

    // basic 1 kHz with latency and one-cycle valid
    push(1'b0, 32'd1000);
    send4(50_000, 50_000, 50_000, 50_000);
    c0 = cyc;
    wait_results(1);
    @(posedge clk); #1; @(posedge clk); #1;
    check("latency_edges", 64'(rise_cyc - c0), 64'd41);
    check("valid_cycles", 64'(vlen), 64'd1);

    push(1'b0, 32'd1000);
    send4(49_999, 50_000, 50_001, 50_000);
    wait_results(2);
    push(1'b0, 32'd15_384_615);
    send4(3, 3, 3, 4);
    wait_results(3);

    // zero divisor, then recovery
    push(1'b1, 32'd0);
    send4(0, 0, 0, 0);
    wait_results(4);
    push(1'b0, 32'd500_000);
    send4(100, 100, 100, 100);
    wait_results(5);

    // consumer stall with upstream holding a sample
    freq_ready = 1'b0;
    push(1'b0, 32'd50_000);
    send4(1000, 1000, 1000, 1000);
    k = 0;
    while (!freq_valid && k < 200) begin @(posedge clk); #1; k++; end
    check("stall_valid_seen", 64'(freq_valid), 64'd1);
    period_valid = 1'b1; period_in = 24'd7;
    repeat (20) begin
      @(negedge clk);
      check("stall_period_ready", 64'(period_ready), 64'd0);
      @(posedge clk); #1;
    end
    freq_ready = 1'b1;
    @(posedge clk); #1;
    check("ack_busy", 64'(busy), 64'd0);
    // held sample must go in exactly once, on the first ACC cycle
    push(1'b0, 32'd7_142_857);
    send(7);
    check("one_sample_busy", 64'(busy), 64'd0);
    send(7); send(7); send(7);
    wait_results(7);

    // reset mid-DIV discards the partial result
    send4(10, 10, 10, 10);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("middiv_busy", 64'(busy), 64'd0);
    check("middiv_period_ready", 64'(period_ready), 64'd1);
    check("middiv_freq_valid", 64'(freq_valid), 64'd0);
    repeat (60) @(posedge clk);
    #1 check("middiv_no_result", 64'(results), 64'd7);
    push(1'b0, 32'd2000);
    send4(25_000, 25_000, 25_000, 25_000);
    wait_results(8);
    check("queue_drained", 64'(expq.size()), 64'd0);

    // QW=16 saturation
    s_valid = 1'b1; s_in = 24'd1;
    repeat (4) @(posedge clk);
    #1 s_valid = 1'b0;
    k = 0;
    while (!s_fv && k < 200) begin @(posedge clk); #1; k++; end
    check("sat_valid", 64'(s_fv), 64'd1);
    check("sat_freq_out", 64'(s_out), 64'hFFFF);
    check("sat_div_err", 64'(s_err), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
